mem_sp_arbiter: RTL and testbench
=================================

Name: mem_sp_arbiter

Overview:
- Round-robin arbiter that shares one single-port SRAM wrapper between NUM_REQ requesters (`mem_sp_sky130`-style: 1 op/cycle, registered read data).
- Grants at most one read or write per cycle, with an optional burst hold per requester.
- Tracks outstanding reads in a READ_LAT-deep pipeline and steers returned data back to the owning requester with a one-cycle rvalid pulse.
- Sits between compute-core SRAM clients (weight/KV loaders, writeback) and the memory wrapper.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- DATA_BIT, 128, SRAM word width; must match the wrapper.
- DEPTH, 512, SRAM depth in words.
- ADDR_BIT, $clog2(DEPTH), address width.
- READ_LAT, 2, cycles from grant to valid mem_rdata (wrapper: macro read + output register).
- MAX_BURST, 4, max consecutive grants to one requester while others wait; 1 = pure round-robin.
- ID_BIT, $clog2(NUM_REQ), requester index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-requester request valid.
- req_wen  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_BIT  packed addresses; requester i at [i*ADDR_BIT +: ADDR_BIT].
- req_wdata  in  NUM_REQ*DATA_BIT  packed write data.
- gnt  out  NUM_REQ  one-hot accept (ready); a transfer happens when req[i] & gnt[i].
- rsp_valid  out  NUM_REQ  one-hot read-data-valid pulse.
- rsp_data  out  DATA_BIT  read data, shared by all requesters; qualified by rsp_valid.
- mem_wen  out  1  to wrapper wen.
- mem_ren  out  1  to wrapper ren.
- mem_addr  out  ADDR_BIT  to wrapper addr.
- mem_wdata  out  DATA_BIT  to wrapper wdata.
- mem_rdata  in  DATA_BIT  from wrapper rdata.

Behaviour:
- Reset (async, rst=1):
  - gnt=0, rsp_valid=0, rsp_data=0.
  - Round-robin pointer=0, burst owner invalid, burst count=0.
  - Read-tracking pipeline cleared. Any in-flight read is dropped; no rsp_valid is issued for it after reset.
- Grant (combinational from req, pointer, burst state):
  - Burst continuation: if the burst owner still requests and burst count < MAX_BURST, the owner wins.
  - Otherwise, round-robin search starts at the pointer; the first requesting index wins.
  - No request → gnt=0, mem_wen=0, mem_ren=0; mem_addr and mem_wdata hold their last granted values.
- Memory drive (combinational from the winner k):
  - mem_addr = req_addr[k].
  - mem_wdata = req_wdata[k].
  - mem_wen = req_wen[k]; mem_ren = ~req_wen[k].
  - Requests are sampled by the wrapper at the same posedge.
- State update (posedge, on a grant to k):
  - pointer ← (k+1) mod NUM_REQ.
  - If k == burst owner: count ← count+1; else owner ← k and count ← 1.
  - No grant in a cycle: owner invalid, count=0.
  - When count reaches MAX_BURST, k loses priority the next cycle if any other requester is active. If k is the only requester it keeps being granted and count restarts at 1.
- Read tracking:
  - A shift pipeline of {valid, id} of depth READ_LAT is pushed on every cycle (valid=1 on a read grant).
  - At the tail: rsp_valid[id] ← 1 for one cycle, and rsp_data ← mem_rdata, so mem_rdata is sampled exactly READ_LAT cycles after the grant.
  - Writes occupy a slot with valid=0.
  - Back-to-back reads sustain 1/cycle; responses return in grant order.
- Boundaries:
  - Simultaneous requests from all requesters → exactly one grant, never zero.
  - A write followed next cycle by a read to the same address returns the new data; the wrapper handles this and the arbiter does not reorder.
  - req dropped without gnt is legal (no side effect).
  - Pointer wraps NUM_REQ-1 → 0.
  - Address out of range is not checked.

Decomposition:
- Shared package `mem_arb_pkg`:
  - READ_LAT default.
  - The typedef for the tracking entry {valid, id}.
  - A localparam for the default MAX_BURST.
- Sub-module `rr_pick`: combinational round-robin priority picker (req vector + pointer → one-hot + index). It is reused by the other arbiters.

Test Plan:
1. Reset mid-read: issue a read from req0 at addr 5, assert rst at +1 cycle → rsp_valid stays 0 through +4 cycles; gnt=0 during reset.
2. Single requester: req1 writes 0xA5A5…A5 to addr 3, then reads addr 3 → rsp_valid=2'b10 exactly 2 cycles after the read grant, rsp_data=0xA5A5…A5.
3. Contention with MAX_BURST=1: req0 and req1 both read continuously (addrs 0..7 and 100..107) → grants alternate 01,10,01,…, responses tagged to the matching id in order.
4. Burst with MAX_BURST=4: both requesters continuously active → grant sequence 0,0,0,0,1,1,1,1,0…; a lone requester gets unbroken grants.
5. Interleaved ops: req0 writes addr 10 while req1 reads addr 20 back-to-back → one op per cycle, mem_wen/mem_ren are exclusive, req1 receives its data 2 cycles after its grant.
6. Idle gap: no requests for 3 cycles, then req1 arrives with pointer=1 → immediate grant; burst count restarts at 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the SRAM port arbiters.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Default cycles from grant to valid wrapper read data
    // (macro read + wrapper output register).
    localparam int READ_LAT_DEF  = 2;

    // Default number of consecutive grants one requester may take while others wait.
    localparam int MAX_BURST_DEF = 4;

    // Requester id field in a tracking entry. It is sized for the largest arbiter
    // that uses this package, so one entry type serves every instance.
    localparam int TRK_ID_BIT    = 8;

    // One slot of the read-tracking pipeline.
    typedef struct packed {
        logic                  vld;
        logic [TRK_ID_BIT-1:0] id;
    } trk_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: the first requester at or after ptr_i wins.
// Latency: combinational.
// Backpressure: none; any_o is low when no requester is active.
//   req_i : request vector
//   ptr_i : index that has highest priority
//   gnt_o : one-hot winner
//   idx_o : winner index
//   any_o : at least one request
module rr_pick #(
    parameter int N   = 2,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    int             j;
    logic [IDW-1:0] j_idx;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        j_idx = '0;
        for (int off = 0; off < N; off++) begin
            // Wrap the search from ptr_i back to index 0.
            j = int'(ptr_i) + off;
            if (j >= N) begin
                j = j - N;
            end
            j_idx = IDW'(j);
            if (!any_o && req_i[j_idx]) begin
                any_o        = 1'b1;
                idx_o        = j_idx;
                gnt_o[j_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_sp_arbiter.sv
// Round-robin, burst-capable arbiter sharing one single-port SRAM wrapper between NUM_REQ clients.
// Latency: the grant is combinational. Read data returns READ_LAT+1 cycles after the grant cycle,
//          which is READ_LAT clock edges after the edge that accepts the request.
// Backpressure: gnt is the ready signal. Only one requester is accepted per cycle, and the others wait.
//   clk, rst          : clock, async active-high reset
//   req/req_wen       : per-requester valid and write select
//   req_addr/wdata    : packed per-requester address and write data
//   gnt               : one-hot accept
//   rsp_valid/data    : one-hot read-return pulse and shared read data
//   mem_*             : single-port wrapper interface
module mem_sp_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int DATA_BIT  = 128,
    parameter int DEPTH     = 512,
    parameter int ADDR_BIT  = $clog2(DEPTH),
    parameter int READ_LAT  = READ_LAT_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int ID_BIT    = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_wen,
    input  logic [NUM_REQ*ADDR_BIT-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_BIT-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_BIT-1:0]          rsp_data,
    output logic                         mem_wen,
    output logic                         mem_ren,
    output logic [ADDR_BIT-1:0]          mem_addr,
    output logic [DATA_BIT-1:0]          mem_wdata,
    input  logic [DATA_BIT-1:0]          mem_rdata
);

    localparam int                CNT_BIT   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_BIT-1:0] BURST_LIM = CNT_BIT'(MAX_BURST);
    localparam logic [ID_BIT-1:0]  LAST_ID   = ID_BIT'(NUM_REQ - 1);

    // Arbitration state
    logic [ID_BIT-1:0]   ptr_q,     ptr_d;
    logic [ID_BIT-1:0]   own_q,     own_d;
    logic                own_vld_q, own_vld_d;
    logic [CNT_BIT-1:0]  cnt_q,     cnt_d;
    logic [ADDR_BIT-1:0] addr_q;
    logic [DATA_BIT-1:0] wdata_q;

    trk_t                trk_q [READ_LAT];
    trk_t                trk_in;
    trk_t                trk_tail;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_BIT-1:0] rsp_data_q;

    // Unpacked views of the packed request buses
    logic [ADDR_BIT-1:0] addr_arr  [NUM_REQ];
    logic [DATA_BIT-1:0] wdata_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_BIT +: ADDR_BIT];
            wdata_arr[i] = req_wdata[i*DATA_BIT +: DATA_BIT];
        end
    end

    logic [NUM_REQ-1:0] pick_oh;
    logic [ID_BIT-1:0]  pick_idx;
    logic               pick_any;

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (ID_BIT)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_oh),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // The burst owner keeps the port until it has taken MAX_BURST grants in a row.
    logic              hold;
    logic [ID_BIT-1:0] win;
    logic              win_vld;

    assign hold    = own_vld_q && req[own_q] && (cnt_q < BURST_LIM);
    assign win     = hold ? own_q : pick_idx;
    // Gate on rst so that no request is accepted or reaches the macro while in reset.
    assign win_vld = !rst && (hold || pick_any);

    always_comb begin
        gnt = '0;
        if (win_vld) begin
            gnt[win] = 1'b1;
        end
    end

    assign mem_wen   = win_vld &&  req_wen[win];
    assign mem_ren   = win_vld && !req_wen[win];
    assign mem_addr  = win_vld ? addr_arr[win]  : addr_q;
    assign mem_wdata = win_vld ? wdata_arr[win] : wdata_q;

    // Next arbitration state
    always_comb begin
        ptr_d     = ptr_q;
        own_d     = own_q;
        own_vld_d = 1'b0;
        cnt_d     = '0;
        if (win_vld) begin
            ptr_d     = (win == LAST_ID) ? '0 : win + 1'b1;
            own_vld_d = 1'b1;
            // When the count is exhausted and the owner wins again (it was alone),
            // it starts a fresh burst.
            if (own_vld_q && (own_q == win) && (cnt_q < BURST_LIM)) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                own_d = win;
                cnt_d = CNT_BIT'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            own_q     <= '0;
            own_vld_q <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            ptr_q     <= ptr_d;
            own_q     <= own_d;
            own_vld_q <= own_vld_d;
            cnt_q     <= cnt_d;
            if (win_vld) begin
                addr_q  <= addr_arr[win];
                wdata_q <= wdata_arr[win];
            end
        end
    end

    // Read tracking: one slot per cycle, so the tail lines up with mem_rdata.
    always_comb begin
        trk_in     = '0;
        trk_in.vld = mem_ren;
        trk_in.id  = TRK_ID_BIT'(win);
    end

    assign trk_tail = trk_q[READ_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                trk_q[i] <= '0;
            end
        end else begin
            trk_q[0] <= trk_in;
            for (int i = 1; i < READ_LAT; i++) begin
                trk_q[i] <= trk_q[i-1];
            end
        end
    end

    logic [NUM_REQ-1:0] tail_oh;

    always_comb begin
        tail_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tail_oh[i] = trk_tail.vld && (trk_tail.id == TRK_ID_BIT'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= tail_oh;
            if (trk_tail.vld) begin
                rsp_data_q <= mem_rdata;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_sp_arbiter.sv
module tb_mem_sp_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req = 2'b00;
    logic [1:0]   req_wen = 2'b00;
    logic [17:0]  req_addr = '0;
    logic [255:0] req_wdata = '0;

    logic [1:0]   gnt_w       [2];
    logic [1:0]   rsp_valid_w [2];
    logic [127:0] rsp_data_w  [2];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0]   oh;
        logic [127:0] dat;
        int           edge_n;
    } sb_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Instance 0 bursts up to 4 grants, and instance 1 is pure round-robin. Both see the same stimulus.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int MB = (g == 0) ? 4 : 1;

        logic         mem_wen, mem_ren;
        logic [8:0]   mem_addr;
        logic [127:0] mem_wdata, mem_rdata, rd_s1;
        logic [127:0] mem     [512];
        logic [127:0] ref_mem [512];
        sb_t          sb_q [$];
        sb_t          e;
        logic         k;
        logic [8:0]   ak;

        mem_sp_arbiter #(
            .NUM_REQ   (2),
            .DATA_BIT  (128),
            .DEPTH     (512),
            .READ_LAT  (2),
            .MAX_BURST (MB)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req       (req),
            .req_wen   (req_wen),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .gnt       (gnt_w[g]),
            .rsp_valid (rsp_valid_w[g]),
            .rsp_data  (rsp_data_w[g]),
            .mem_wen   (mem_wen),
            .mem_ren   (mem_ren),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata)
        );

        initial begin
            rd_s1     = '0;
            mem_rdata = '0;
            for (int i = 0; i < 512; i++) begin
                mem[i]     = {4{i[31:0] * 32'h9E37_79B1}};
                ref_mem[i] = {4{i[31:0] * 32'h9E37_79B1}};
            end
        end

        // Wrapper model: macro read register plus output register.
        always @(posedge clk) begin
            if (mem_wen) mem[mem_addr] <= mem_wdata;
            if (mem_ren) rd_s1 <= mem[mem_addr];
            mem_rdata <= rd_s1;
        end

        // Scoreboard: push expected read data at grant, and pop it on rsp_valid.
        always @(negedge clk) begin
            if (rst) begin
                sb_q.delete();
            end else begin
                if (rsp_valid_w[g] != 2'b00) begin
                    if (sb_q.size() == 0) begin
                        chk("rsp_unexpected", 128'(rsp_valid_w[g]), 128'(0));
                    end else begin
                        e = sb_q.pop_front();
                        chk("rsp_id", 128'(rsp_valid_w[g]), 128'(e.oh));
                        chk("rsp_data", rsp_data_w[g], e.dat);
                        chk("rsp_latency", 128'(cyc), 128'(e.edge_n + 2));
                    end
                end
                if (req != 2'b00) chk("gnt_any", 128'(|gnt_w[g]), 128'(1));
                if (gnt_w[g] != 2'b00) begin
                    k  = gnt_w[g][1];
                    ak = k ? req_addr[17:9] : req_addr[8:0];
                    chk("gnt_onehot", 128'($countones(gnt_w[g])), 128'(1));
                    chk("gnt_without_req", 128'(gnt_w[g] & ~req), 128'(0));
                    chk("mem_addr", 128'(mem_addr), 128'(ak));
                    chk("mem_op", 128'({mem_wen, mem_ren}), req_wen[k] ? 128'(2) : 128'(1));
                    if (req_wen[k]) begin
                        chk("mem_wdata", mem_wdata, k ? req_wdata[255:128] : req_wdata[127:0]);
                        ref_mem[ak] = mem_wdata;
                    end else begin
                        sb_q.push_back('{gnt_w[g], ref_mem[ak], cyc + 1});
                    end
                end else begin
                    chk("mem_idle", 128'({mem_wen, mem_ren}), 128'(0));
                end
            end
        end
    end

    task automatic drive(input logic [1:0] r, input logic [1:0] w,
                         input logic [8:0] a0, input logic [8:0] a1,
                         input logic [127:0] d0, input logic [127:0] d1);
        req       = r;
        req_wen   = w;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_b, exp_r;

    initial begin
        // Reset state, including requests held while in reset
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_gnt", 128'(gnt_w[g]), 128'(0));
            chk("rst_rsp_valid", 128'(rsp_valid_w[g]), 128'(0));
            chk("rst_rsp_data", rsp_data_w[g], 128'(0));
        end
        drive(2'b01, 2'b00, 9'd5, 9'd0, '0, '0);
        @(negedge clk);
        chk("rst_gnt_req", 128'(gnt_w[0]), 128'(0));

        // Reset mid-read: a read is accepted, then reset one cycle later drops it
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("t1_gnt", 128'(gnt_w[0]), 128'(1));
        chk("t1_gnt_rr", 128'(gnt_w[1]), 128'(1));
        next_cycle();
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t1_gnt_in_rst", 128'(gnt_w[0]), 128'(0));
            chk("t1_rsp_in_rst", 128'(rsp_valid_w[0]), 128'(0));
        end
        next_cycle();
        rst = 1'b0;
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        repeat (4) begin
            @(negedge clk);
            chk("t1_rsp_dropped", 128'(rsp_valid_w[0]), 128'(0));
        end

        // Single requester: write then read addr 3
        next_cycle();
        drive(2'b10, 2'b10, '0, 9'd3, '0, {16{8'hA5}});
        @(negedge clk);
        chk("t2_wr_gnt", 128'(gnt_w[0]), 128'(2));
        next_cycle();
        drive(2'b10, 2'b00, '0, 9'd3, '0, '0);
        @(negedge clk);
        chk("t2_rd_gnt", 128'(gnt_w[0]), 128'(2));
        chk("t2_rd_gnt_rr", 128'(gnt_w[1]), 128'(2));
        next_cycle();
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        @(negedge clk);
        chk("t2_rsp_early1", 128'(rsp_valid_w[0]), 128'(0));
        @(negedge clk);
        chk("t2_rsp_early2", 128'(rsp_valid_w[0]), 128'(0));
        @(negedge clk);
        chk("t2_rsp_valid", 128'(rsp_valid_w[0]), 128'(2));
        chk("t2_rsp_data", rsp_data_w[0], {16{8'hA5}});
        @(negedge clk);
        chk("t2_rsp_pulse", 128'(rsp_valid_w[0]), 128'(0));

        // Contention: both read continuously. Burst 0000 1111 00 vs. round-robin 0101...
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            drive(2'b11, 2'b00, 9'(i), 9'(100 + i), '0, '0);
            @(negedge clk);
            exp_b = (i < 4 || i >= 8) ? 2'b01 : 2'b10;
            exp_r = (i % 2 == 1) ? 2'b10 : 2'b01;
            chk("t34_gnt_burst", 128'(gnt_w[0]), 128'(exp_b));
            chk("t34_gnt_rr", 128'(gnt_w[1]), 128'(exp_r));
            next_cycle();
        end

        // Lone requester gets unbroken grants, including past the burst limit
        for (int i = 0; i < 6; i++) begin
            drive(2'b01, 2'b00, 9'(200 + i), '0, '0, '0);
            @(negedge clk);
            chk("t4_lone_burst", 128'(gnt_w[0]), 128'(1));
            chk("t4_lone_rr", 128'(gnt_w[1]), 128'(1));
            next_cycle();
        end

        // Idle gap, then req1 arrives with the pointer at 1
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        repeat (3) next_cycle();
        drive(2'b10, 2'b00, '0, 9'd20, '0, '0);
        @(negedge clk);
        chk("t6_gnt_burst", 128'(gnt_w[0]), 128'(2));
        chk("t6_gnt_rr", 128'(gnt_w[1]), 128'(2));
        next_cycle();

        // req0 writes addr 10 while req1 reads addr 20. The burst count restarted at 1.
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 2'b01, 9'd10, 9'd20, {4{32'(i) + 32'hC0DE_0000}}, '0);
            @(negedge clk);
            exp_b = (i < 3 || i == 7) ? 2'b10 : 2'b01;
            exp_r = (i % 2 == 1) ? 2'b10 : 2'b01;
            chk("t5_gnt_burst", 128'(gnt_w[0]), 128'(exp_b));
            chk("t5_gnt_rr", 128'(gnt_w[1]), 128'(exp_r));
            next_cycle();
        end

        // Write followed next cycle by a read of the same address
        drive(2'b01, 2'b01, 9'd7, '0, {4{32'hDEAD_BEEF}}, '0);
        next_cycle();
        drive(2'b10, 2'b00, '0, 9'd7, '0, '0);
        next_cycle();
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("raw_rsp_valid", 128'(rsp_valid_w[0]), 128'(2));
        chk("raw_rsp_data", rsp_data_w[0], {4{32'hDEAD_BEEF}});

        repeat (6) next_cycle();
        chk("sb_drain_burst", 128'(g_dut[0].sb_q.size()), 128'(0));
        chk("sb_drain_rr", 128'(g_dut[1].sb_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
